// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multicycle MIPS-subset control unit.
//   state_t  : 4-bit controller state with fixed debug encodings
//   OP_*     : supported instr[31:26] opcodes
//   ALU_*    : alu_op codes, PCSRC_* : next-PC select, SRCB_* : ALU B-input select
//   ctrl_t   : control vector produced by mc_decode
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational control-vector decode.
// Ports:
//   i_state     : current controller state
//   i_opcode    : instr[31:26]
//   i_zero      : ALU zero flag (qualifies the branch PC load)
//   i_mem_ready : memory handshake (qualifies the fetch IR/PC load)
//   i_pc_over   : fetch address beyond the legal limit (tied 0 when the limit is disabled)
//   o_ctrl      : control vector; every field not named for a state is 0
module mc_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    input  logic       i_pc_over,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                // An out-of-range fetch issues nothing; the FSM heads to HALT.
                if (!i_pc_over) begin
                    o_ctrl.iord      = 1'b0;
                    o_ctrl.mem_read  = 1'b1;
                    o_ctrl.alu_src_a = 1'b0;
                    o_ctrl.alu_src_b = SRCB_FOUR;
                    o_ctrl.alu_op    = ALU_ADD;
                    o_ctrl.pc_src    = PCSRC_SEQ;
                    o_ctrl.ir_write  = i_mem_ready;
                    o_ctrl.pc_en     = i_mem_ready;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                o_ctrl.alu_src_a  = 1'b0;
                o_ctrl.alu_src_b  = SRCB_IMM_SH;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.illegal_op = !is_supported(i_opcode);
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
                o_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_SUB;
                o_ctrl.pc_src    = PCSRC_BR;
                o_ctrl.pc_en     = i_zero;
            end
            S_JUMP: begin
                o_ctrl.pc_src = PCSRC_JMP;
                o_ctrl.pc_en  = 1'b1;
            end
            S_ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b0;
                o_ctrl.reg_write  = 1'b1;
            end
            default: o_ctrl = '0;   // HALT and unused encodings drive nothing
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle main control unit for the 32-bit MIPS-subset core.
// Holds the state register and next-state logic; control outputs are decoded
// combinationally from state (plus opcode/zero/mem_ready) by mc_decode.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset (state -> FETCH)
//   opcode, zero     : instr[31:26] and ALU zero flag
//   mem_ready        : memory access completes this cycle (FETCH/MEM_RD/MEM_WR only)
//   pc               : current PC (only used with MC_PC_LIMIT_EN)
//   pc_en..alu_op    : datapath control strobes and selects
//   illegal_op       : pulse in DECODE for an unsupported opcode
//   halted           : controller is in HALT
//   state            : current state encoding for debug
// Build option: define MC_PC_LIMIT_EN to halt when a fetch is attempted above PC_LIMIT.
module mc_control
    import mc_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] PC_LIMIT = 10'd64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    input  logic [PC_W-1:0] pc,
    output logic            pc_en,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            illegal_op,
    output logic            halted,
    output logic [3:0]      state
);

    state_t r_state;
    state_t w_state_next;
    ctrl_t  w_ctrl;
    logic   w_pc_over;

`ifdef MC_PC_LIMIT_EN
    assign w_pc_over = (r_state == S_FETCH) && (pc > PC_LIMIT);
    assign halted    = (r_state == S_HALT);
`else
    logic w_unused_pc;
    assign w_unused_pc = ^{pc, PC_LIMIT};
    assign w_pc_over   = 1'b0;
    assign halted      = 1'b0;
`endif

    mc_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_zero      (zero),
        .i_mem_ready (mem_ready),
        .i_pc_over   (w_pc_over),
        .o_ctrl      (w_ctrl)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_pc_over)      w_state_next = S_HALT;
                else if (mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEM_ADDR;
                    OP_R:         w_state_next = S_R_EXEC;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_ADDI:      w_state_next = S_ADDI_EXEC;
                    default:      w_state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      w_state_next = S_MEM_RD;
                else if (opcode == OP_SW) w_state_next = S_MEM_WR;
                else                      w_state_next = S_FETCH;
            end
            S_MEM_RD:    if (mem_ready) w_state_next = S_MEM_WB;
            S_MEM_WB:    w_state_next = S_FETCH;
            S_MEM_WR:    if (mem_ready) w_state_next = S_FETCH;
            S_R_EXEC:    w_state_next = S_R_WB;
            S_R_WB:      w_state_next = S_FETCH;
            S_BRANCH:    w_state_next = S_FETCH;
            S_JUMP:      w_state_next = S_FETCH;
            S_ADDI_EXEC: w_state_next = S_ADDI_WB;
            S_ADDI_WB:   w_state_next = S_FETCH;
            S_HALT:      w_state_next = S_HALT;   // only rst leaves HALT
            default:     w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_next;
    end

    // State-changing strobes are masked during reset: FETCH is decoded while
    // rst is held, and mem_ready may already be high.
    assign pc_en      = w_ctrl.pc_en      & ~rst;
    assign ir_write   = w_ctrl.ir_write   & ~rst;
    assign mem_write  = w_ctrl.mem_write  & ~rst;
    assign reg_write  = w_ctrl.reg_write  & ~rst;
    assign illegal_op = w_ctrl.illegal_op & ~rst;

    assign pc_src     = w_ctrl.pc_src;
    assign iord       = w_ctrl.iord;
    assign mem_read   = w_ctrl.mem_read;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_op     = w_ctrl.alu_op;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks LW, a stalled fetch, R, BEQ taken and
// not taken, J, an illegal opcode, SW interrupted by reset, ADDI and the PC limit.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [9:0] pc;
    logic       pc_en, ir_write, iord, mem_read, mem_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       illegal_op, halted;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mc_control #(.PC_W(10), .PC_LIMIT(10'd64)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .halted     (halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs may be changed right after and sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b100011; zero = 1'b0; mem_ready = 1'b1; pc = 10'd0;
        #2;
        chk("rst_state",    32'(state), 0);
        chk("rst_pc_en",    32'(pc_en), 0);
        chk("rst_ir_write", 32'(ir_write), 0);
        chk("rst_halted",   32'(halted), 0);
        step();
        rst = 1'b0;
        #1;
        // LW: 0,1,2,3,4,0
        chk("lw_f_ir_write", 32'(ir_write), 1);
        chk("lw_f_pc_en",    32'(pc_en), 1);
        chk("lw_f_srcb",     32'(alu_src_b), 1);
        step();
        chk("lw_dec_state",  32'(state), 1);
        chk("lw_dec_srcb",   32'(alu_src_b), 3);
        chk("lw_dec_wr",     32'(reg_write), 0);
        step();
        chk("lw_addr_state", 32'(state), 2);
        chk("lw_addr_srca",  32'(alu_src_a), 1);
        chk("lw_addr_srcb",  32'(alu_src_b), 2);
        step();
        chk("lw_rd_state",   32'(state), 3);
        chk("lw_rd_iord",    32'(iord), 1);
        chk("lw_rd_read",    32'(mem_read), 1);
        chk("lw_rd_m2r",     32'(mem_to_reg), 0);
        step();
        chk("lw_wb_state",   32'(state), 4);
        chk("lw_wb_regwr",   32'(reg_write), 1);
        chk("lw_wb_m2r",     32'(mem_to_reg), 1);
        chk("lw_wb_regdst",  32'(reg_dst), 0);
        step();
        chk("lw_end_state",  32'(state), 0);

        // Stalled fetch (R-type): 3 cycles waiting, then one load pulse
        opcode = 6'b000000; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_state",    32'(state), 0);
            chk("stall_ir_write", 32'(ir_write), 0);
            chk("stall_pc_en",    32'(pc_en), 0);
            chk("stall_mem_read", 32'(mem_read), 1);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_rel_ir", 32'(ir_write), 1);
        chk("stall_rel_pc", 32'(pc_en), 1);
        step();
        chk("r_dec_state",  32'(state), 1);
        chk("r_dec_ir",     32'(ir_write), 0);
        step();
        chk("r_exec_state", 32'(state), 6);
        chk("r_exec_aluop", 32'(alu_op), 2);
        chk("r_exec_srcb",  32'(alu_src_b), 0);
        step();
        chk("r_wb_state",   32'(state), 7);
        chk("r_wb_regdst",  32'(reg_dst), 1);
        chk("r_wb_regwr",   32'(reg_write), 1);
        step();
        chk("r_end_state",  32'(state), 0);

        // BEQ taken
        opcode = 6'b000100; zero = 1'b1;
        step(); step();
        chk("beq1_state",  32'(state), 8);
        chk("beq1_pc_en",  32'(pc_en), 1);
        chk("beq1_pc_src", 32'(pc_src), 1);
        chk("beq1_aluop",  32'(alu_op), 1);
        step();
        chk("beq1_end",    32'(state), 0);
        // BEQ not taken
        zero = 1'b0;
        step(); step();
        chk("beq0_state",  32'(state), 8);
        chk("beq0_pc_en",  32'(pc_en), 0);
        step();

        // J
        opcode = 6'b000010;
        step(); step();
        chk("j_state",   32'(state), 9);
        chk("j_pc_en",   32'(pc_en), 1);
        chk("j_pc_src",  32'(pc_src), 2);
        step();
        chk("j_end",     32'(state), 0);

        // Illegal opcode
        opcode = 6'b111111;
        #1;
        chk("ill_fetch_pulse", 32'(illegal_op), 0);
        step();
        chk("ill_dec_state", 32'(state), 1);
        chk("ill_pulse",     32'(illegal_op), 1);
        step();
        chk("ill_ret_state", 32'(state), 0);
        chk("ill_pulse_off", 32'(illegal_op), 0);

        // SW interrupted by reset while waiting for memory
        opcode = 6'b101011;
        step(); step(); step();
        mem_ready = 1'b0;
        #1;
        chk("sw_wr_state", 32'(state), 5);
        chk("sw_wr_write", 32'(mem_write), 1);
        chk("sw_wr_iord",  32'(iord), 1);
        step();
        chk("sw_hold_state", 32'(state), 5);
        chk("sw_hold_write", 32'(mem_write), 1);
        rst = 1'b1;
        #1;
        chk("sw_rst_state", 32'(state), 0);
        chk("sw_rst_write", 32'(mem_write), 0);
        step();
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        chk("sw_post_state", 32'(state), 0);
        chk("sw_post_regwr", 32'(reg_write), 0);
        chk("sw_post_write", 32'(mem_write), 0);

        // ADDI
        opcode = 6'b001000;
        step(); step();
        chk("addi_ex_state", 32'(state), 10);
        chk("addi_ex_srcb",  32'(alu_src_b), 2);
        step();
        chk("addi_wb_state", 32'(state), 11);
        chk("addi_wb_regwr", 32'(reg_write), 1);
        chk("addi_wb_m2r",   32'(mem_to_reg), 0);
        step();
        chk("addi_end",      32'(state), 0);

        // Fetch above the PC limit
        pc = 10'd68;
        #1;
`ifdef MC_PC_LIMIT_EN
        chk("lim_fetch_read", 32'(mem_read), 0);
        chk("lim_fetch_ir",   32'(ir_write), 0);
        step();
        chk("lim_halt_state", 32'(state), 12);
        chk("lim_halted",     32'(halted), 1);
        step();
        chk("lim_hold_state", 32'(state), 12);
        chk("lim_hold_read",  32'(mem_read), 0);
        chk("lim_hold_pc_en", 32'(pc_en), 0);
        rst = 1'b1;
        #1;
        chk("lim_rst_state",  32'(state), 0);
        chk("lim_rst_halted", 32'(halted), 0);
        rst = 1'b0;
`else
        chk("nolim_read",   32'(mem_read), 1);
        chk("nolim_ir",     32'(ir_write), 1);
        step();
        chk("nolim_state",  32'(state), 1);
        chk("nolim_halted", 32'(halted), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
